// File: rtl/alu_executor_pkg.sv
// Shared ALU definitions: op-code constants, shifter mode and op-class helpers.
// Decode and the execute-stage ALU both import this package.
package alu_executor_pkg;

    localparam int ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'd9;

    typedef enum logic [1:0] {
        SH_LEFT        = 2'd0,
        SH_RIGHT_LOGIC = 2'd1,
        SH_RIGHT_ARITH = 2'd2
    } shift_mode_t;

    function automatic logic is_shift_op(input logic [ALU_CTRL_W-1:0] ctl);
        return (ctl == ALU_SLL) || (ctl == ALU_SRL) || (ctl == ALU_SRA);
    endfunction

    function automatic logic is_legal_op(input logic [ALU_CTRL_W-1:0] ctl);
        return ctl <= ALU_AND;
    endfunction

endpackage

// File: rtl/alu_executor_if.sv
// Request/result bundle between decode, the execute-stage ALU and writeback/PC logic.
interface alu_executor_if #(
    parameter int XLEN = 32
);
    import alu_executor_pkg::*;

    logic                  inValid;
    logic                  inReady;
    logic [ALU_CTRL_W-1:0] aluControl;
    logic                  reversedZFlag;
    logic [XLEN-1:0]       srcA;
    logic [XLEN-1:0]       srcB;
    logic                  outValid;
    logic                  outReady;
    logic [XLEN-1:0]       aluResult;
    logic                  zFlag;
    logic                  branchTaken;
    logic                  illegalOp;

    modport master (
        output inValid, aluControl, reversedZFlag, srcA, srcB, outReady,
        input  inReady, outValid, aluResult, zFlag, branchTaken, illegalOp
    );

    modport slave (
        input  inValid, aluControl, reversedZFlag, srcA, srcB, outReady,
        output inReady, outValid, aluResult, zFlag, branchTaken, illegalOp
    );

endinterface

// File: rtl/alu_executor_serial_shifter.sv
// Iterative 1-bit-per-cycle shifter. done flags the cycle whose edge retires the last
// bit, with dout_next already holding the final value so the caller can register it then.
module alu_serial_shifter
    import alu_executor_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SH_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  shift_mode_t     mode,
    input  logic [XLEN-1:0] din,
    input  logic [SH_W-1:0] shamt,
    output logic            done,
    output logic [XLEN-1:0] dout_next
);

    logic [XLEN-1:0]        work;
    logic signed [XLEN-1:0] work_s;
    logic [SH_W-1:0]        cnt;
    logic                   busy;
    shift_mode_t            mode_q;

    assign work_s = work;
    assign done   = busy && (cnt == SH_W'(1));

    always_comb begin
        dout_next = work;
        case (mode_q)
            SH_LEFT:        dout_next = {work[XLEN-2:0], 1'b0};
            SH_RIGHT_LOGIC: dout_next = work >> 1;
            SH_RIGHT_ARITH: dout_next = work_s >>> 1;
            default:        dout_next = work;
        endcase
    end

    // A zero shift amount never starts the shifter; the caller handles it as a pass-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            mode_q <= SH_LEFT;
        end else if (start && (shamt != '0)) begin
            work   <= din;
            cnt    <= shamt;
            busy   <= 1'b1;
            mode_q <= mode;
        end else if (busy) begin
            work <= dout_next;
            cnt  <= cnt - SH_W'(1);
            if (cnt == SH_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_executor.sv
// RV32I execute-stage ALU: single-cycle arithmetic/logic, serial shifts, registered
// result with zero/branch flags held under output backpressure.
module alu_executor
    import alu_executor_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst_n,
    alu_executor_if.slave bus
);

    localparam int SH_W = $clog2(XLEN);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]      state;
    logic            accept;
    logic            legal;
    logic            shift_start;
    logic [SH_W-1:0] shamt;
    shift_mode_t     sh_mode;
    logic            sh_done;
    logic [XLEN-1:0] sh_next;
    logic [XLEN-1:0] single_res;
    logic            single_z;
    logic            rzf_q;
    logic [XLEN-1:0] result_q;
    logic            z_q;
    logic            br_q;
    logic            ill_q;

    function automatic logic [XLEN-1:0] alu_compute(input logic [ALU_CTRL_W-1:0] ctl,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] as;
        logic signed [XLEN-1:0] bs;
        as = a;
        bs = b;
        case (ctl)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLT:  return {{(XLEN-1){1'b0}}, (as < bs)};
            ALU_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  return a ^ b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            // Only zero-amount shifts reach here; longer ones go through the serial shifter.
            ALU_SLL, ALU_SRL, ALU_SRA: return a;
            default:  return '0;
        endcase
    endfunction

    function automatic shift_mode_t shift_mode_of(input logic [ALU_CTRL_W-1:0] ctl);
        case (ctl)
            ALU_SLL: return SH_LEFT;
            ALU_SRA: return SH_RIGHT_ARITH;
            default: return SH_RIGHT_LOGIC;
        endcase
    endfunction

    assign bus.inReady  = (state == IDLE);
    assign bus.outValid = (state == DONE);
    assign bus.aluResult   = result_q;
    assign bus.zFlag       = z_q;
    assign bus.branchTaken = br_q;
    assign bus.illegalOp   = ill_q;

    assign accept      = bus.inValid && (state == IDLE);
    assign legal       = is_legal_op(bus.aluControl);
    assign shamt       = bus.srcB[SH_W-1:0];
    assign sh_mode     = shift_mode_of(bus.aluControl);
    assign shift_start = accept && is_shift_op(bus.aluControl) && (shamt != '0);
    assign single_res  = legal ? alu_compute(bus.aluControl, bus.srcA, bus.srcB) : '0;
    assign single_z    = (single_res == '0);

    alu_serial_shifter #(
        .XLEN (XLEN),
        .SH_W (SH_W)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (shift_start),
        .mode      (sh_mode),
        .din       (bus.srcA),
        .shamt     (shamt),
        .done      (sh_done),
        .dout_next (sh_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rzf_q    <= 1'b0;
            result_q <= '0;
            z_q      <= 1'b0;
            br_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rzf_q <= bus.reversedZFlag;
                        if (shift_start) begin
                            state <= SHIFT;
                        end else begin
                            state    <= DONE;
                            result_q <= single_res;
                            z_q      <= single_z;
                            br_q     <= single_z ^ bus.reversedZFlag;
                            ill_q    <= !legal;
                        end
                    end
                end
                SHIFT: begin
                    if (sh_done) begin
                        state    <= DONE;
                        result_q <= sh_next;
                        z_q      <= (sh_next == '0);
                        br_q     <= (sh_next == '0) ^ rzf_q;
                        ill_q    <= 1'b0;
                    end
                end
                // Result stays frozen until the consumer takes it; no accept in this cycle.
                DONE: begin
                    if (bus.outReady) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
